lfsr4_checker: RTL
==================

# lfsr4_checker

Downstream consumer of the 4-bit LFSR generator (`LFSR_4`): samples its `lfsr_o` bus and confirms the stream follows the x^4+x^3+1 sequence. The checker self-synchronises to any nonzero phase, declares lock after a run of correct samples, and then counts mismatches. It sits beside the generator in the self-test path and provides the pass/fail observability that the generator lacks.

## Interface
- `LOCK_CNT`, default 4: consecutive correct samples required to enter LOCKED (1..15).
- `UNLOCK_CNT`, default 3: consecutive mismatches in LOCKED that force a drop back to UNLOCKED (1..15).
- `CNT_W`, default 16: width of the error counter.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `en` input, 1 bit: sample qualifier. Tie high when paired with `LFSR_4`.
- `lfsr_i` input, 4 bits: generator output (`lfsr_o`).
- `clr_cnt` input, 1 bit: synchronous clear of `err_cnt`.
- `locked` output, 1 bit: high while in LOCKED.
- `err_o` output, 1 bit: one-cycle pulse per mismatch detected in LOCKED.
- `err_cnt` output, `CNT_W` bits: saturating mismatch count.

## Operation
- Next-value rule: nxt(q) = {q[2:0], q[3]^q[2]}. Period is 15. 4'b0000 is the illegal lock-up value.
- States: UNLOCKED, LOCKING, LOCKED. All actions listed below occur only on cycles where `en`=1. When `en`=0, the state, prediction and counters all hold.
- UNLOCKED:
  - Nonzero sample: set pred=nxt(sample), match_cnt=0, go to LOCKING.
  - Zero sample: stay in UNLOCKED.
- LOCKING:
  - sample==pred: match_cnt++, pred=nxt(sample). When match_cnt reaches `LOCK_CNT`, go to LOCKED.
  - Mismatch: reseed with pred=nxt(sample), match_cnt=0. A zero sample instead returns to UNLOCKED.
- LOCKED:
  - pred free-runs as pred=nxt(pred) and is never reloaded from the input. An isolated bit error therefore produces exactly one mismatch.
  - Mismatch: `err_o` pulses, `err_cnt` increments, miss_cnt++. When miss_cnt reaches `UNLOCK_CNT`, go to UNLOCKED.
  - Match: miss_cnt=0.
- `err_cnt` saturates at 2^CNT_W−1. `err_o` still pulses when the counter is saturated.
- `clr_cnt` takes priority over an increment in the same cycle: the result is 0, and that mismatch is not counted.
- Errors are never counted outside LOCKED.

## Timing
- Reset values: state=UNLOCKED, pred=0, match_cnt=0, miss_cnt=0, `locked`=0, `err_o`=0, `err_cnt`=0.
- Reset has priority over `en` and `clr_cnt`. Asserting reset mid-lock drops `locked` at the next edge.
- All outputs are registered.
- `err_o` is high during the cycle after the edge that sampled the bad value.
- `locked` rises at the edge that samples the `LOCK_CNT`-th consecutive match. Minimum time to lock from reset release is 1+`LOCK_CNT` sampled cycles.
- `locked` falls at the edge that samples the `UNLOCK_CNT`-th consecutive miss. That final miss still pulses `err_o` and is still counted.

## Structure
- Package `lfsr4_pkg` holds:
  - the state enum,
  - the function `lfsr4_next(q)`,
  - the constant `LFSR4_ZERO`.
- The generator re-uses the same function, so the polynomial is defined in one place.
- One sub-module, `sat_counter` (parameter `W`; ports `clk`, `reset`, `clr`, `inc`, `q`), implements `err_cnt`.
- The FSM, prediction register and match/miss counters stay in the top module.

## Test plan
- Clean stream: reset, then feed 0001, 0010, 0100, 1001, 0011, 0110, … with `en`=1. Required: `locked`=1 after the 5th sample; over 60 further samples `err_o` never asserts and `err_cnt`=0.
- Single error: while locked, the expected value 1101 is replaced by 1100, then the stream resumes correctly. Required: exactly one `err_o` pulse one cycle later, `err_cnt`=1, `locked` stays 1.
- Loss of lock: while locked, force 3 consecutive wrong values. Required: `err_cnt`=3 and `locked`=0 after the 3rd. A correct stream then relocks after 5 samples, and `err_cnt` holds at 3.
- Zero input: hold `lfsr_i`=0000 for 10 cycles after reset. Required: stays UNLOCKED, `err_o`=0. A 0000 injected while locked counts as one error.
- Saturation and clear: `CNT_W`=2, inject 5 isolated errors while locked. Required: `err_cnt` sticks at 3 and `err_o` pulses 5 times. Assert `clr_cnt` in the same cycle as a 6th error. Required: `err_cnt`=0.
- `en` gating and reset: deassert `en` for 7 cycles mid-stream while `lfsr_i` keeps changing. Required: no errors, lock held. Assert `reset` mid-lock. Required: all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/lfsr4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lfsr4_pkg                                                  |
// | Brief   : Shared x^4+x^3+1 LFSR definitions for generator & checker  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lfsr4_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } lfsr4_state_t;

    // All-zero is the lock-up value the generator can never leave.
    localparam logic [3:0] LFSR4_ZERO = 4'b0000;

    function automatic logic [3:0] lfsr4_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sat_counter                                                |
// | Brief   : Saturating up-counter with synchronous clear               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] c_one = W'(1);
    localparam logic [W-1:0] c_max = {W{1'b1}};

    logic [W-1:0] r_q;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != c_max)) begin
            r_q <= r_q + c_one;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/lfsr4_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lfsr4_checker                                              |
// | Brief   : Self-synchronising checker for the 4-bit LFSR stream       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lfsr4_checker
    import lfsr4_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       lfsr_i,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] c_lock_cnt   = 4'(LOCK_CNT);
    localparam logic [3:0] c_unlock_cnt = 4'(UNLOCK_CNT);

    lfsr4_state_t r_state, w_state;
    logic [3:0]   r_pred, w_pred;
    logic [3:0]   r_match_cnt, w_match_cnt;
    logic [3:0]   r_miss_cnt, w_miss_cnt;
    logic         r_locked, r_err;
    logic         w_err;
    logic         w_hit;
    logic [3:0]   w_seed;
    logic [3:0]   w_match_inc;
    logic [3:0]   w_miss_inc;

    assign w_hit       = (lfsr_i == r_pred);
    assign w_seed      = lfsr4_next(lfsr_i);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_miss_inc  = r_miss_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_UNLOCKED;
            r_pred      <= LFSR4_ZERO;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pred      <= w_pred;
            r_match_cnt <= w_match_cnt;
            r_miss_cnt  <= w_miss_cnt;
            r_locked    <= (w_state == ST_LOCKED);
            r_err       <= w_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_pred      = r_pred;
        w_match_cnt = r_match_cnt;
        w_miss_cnt  = r_miss_cnt;
        w_err       = 1'b0;
        if (en) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (lfsr_i != LFSR4_ZERO) begin
                        w_pred      = w_seed;
                        w_match_cnt = 4'd0;
                        w_state     = ST_LOCKING;
                    end
                end
                ST_LOCKING: begin
                    if (w_hit) begin
                        w_pred      = w_seed;
                        w_match_cnt = w_match_inc;
                        if (w_match_inc == c_lock_cnt) begin
                            w_state    = ST_LOCKED;
                            w_miss_cnt = 4'd0;
                        end
                    end else if (lfsr_i == LFSR4_ZERO) begin
                        w_match_cnt = 4'd0;
                        w_state     = ST_UNLOCKED;
                    end else begin
                        w_pred      = w_seed;
                        w_match_cnt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    // Prediction free-runs so one corrupted sample costs one error.
                    w_pred = lfsr4_next(r_pred);
                    if (!w_hit) begin
                        w_err      = 1'b1;
                        w_miss_cnt = w_miss_inc;
                        if (w_miss_inc == c_unlock_cnt) begin
                            w_miss_cnt  = 4'd0;
                            w_match_cnt = 4'd0;
                            w_state     = ST_UNLOCKED;
                        end
                    end else begin
                        w_miss_cnt = 4'd0;
                    end
                end
                default: begin
                    w_state = ST_UNLOCKED;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (w_err),
        .q     (err_cnt)
    );

    assign locked = r_locked;
    assign err_o  = r_err;

endmodule
`default_nettype wire
